// File: rtl/wb_net_sequencer_pkg.sv
// Shared definitions for the network bring-up sequencer: command encodings,
// fault codes, FSM states and the network CSR offsets used by command scripts.
package wb_net_sequencer_pkg;

    typedef enum logic [1:0] {
        CMD_WRITE = 2'b00,
        CMD_POLL  = 2'b01,
        CMD_READ  = 2'b10,
        CMD_END   = 2'b11
    } cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_DECODE   = 3'd2,
        ST_REQ      = 3'd3,
        ST_WAIT_ACK = 3'd4,
        ST_FAULT    = 3'd5
    } state_e;

    localparam logic [1:0] FC_NONE        = 2'd0;
    localparam logic [1:0] FC_WB_ERR      = 2'd1;
    localparam logic [1:0] FC_ACK_TIMEOUT = 2'd2;
    localparam logic [1:0] FC_POLL_LIMIT  = 2'd3;

    localparam logic [21:0] OFF_CORE_CTRL         = 22'h000000;
    localparam logic [21:0] OFF_CORE_STATUS       = 22'h000004;
    localparam logic [21:0] OFF_OUTPUT_SOLUTION_0 = 22'h000010;
    localparam logic [21:0] OFF_OUTPUT_SOLUTION_1 = 22'h000011;
    localparam logic [21:0] OFF_OUTPUT_SOLUTION_2 = 22'h000012;

    // Command word: [31:30] CMD, [29:8] offset from BASE_ADDR, [7:0] data or poll mask.
    function automatic logic [31:0] mk_cmd(input cmd_e c, input logic [21:0] off,
                                           input logic [7:0] d);
        return {c, off, d};
    endfunction

endpackage

// File: rtl/wb_net_cmd_rom.sv
// Synchronous command ROM for the sequencer; data appears one cycle after the address.
module wb_net_cmd_rom #(
  parameter int AW = 8
) (
  input  logic          CLK,
  input  logic [AW-1:0] i_addr,
  output logic [31:0]   o_data
);

  logic [31:0] r_mem [2**AW];

  initial begin
    for (int i = 0; i < 2**AW; i++) r_mem[i] = 32'h0000_0000;
  end

  always_ff @(posedge CLK) begin
    o_data <= r_mem[i_addr];
  end

endmodule

// File: rtl/wb_net_sequencer.sv
// Autonomous Wishbone master replaying a write/poll/read script from a command ROM
// into the network top's slave port; captures up to three result bytes.
module wb_net_sequencer
    import wb_net_sequencer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
    parameter int          ROM_AW      = 8,
    parameter int          ACK_TIMEOUT = 255,
    parameter int          POLL_LIMIT  = 65535
) (
    input  logic              CLK,
    input  logic              rstn,
    input  logic              START,
    output logic              BUSY,
    output logic              DONE,
    output logic              FAULT,
    output logic [1:0]        FAULT_CODE,
    output logic [ROM_AW-1:0] ROM_ADDR,
    input  logic [31:0]       ROM_DATA,
    output logic              CYC,
    output logic              STB,
    output logic              WE,
    output logic [31:0]       ADDR,
    output logic [7:0]        WDATA,
    output logic              SEL,
    input  logic              STALL,
    input  logic              ACK,
    input  logic [7:0]        RDATA,
    input  logic              ERR,
    output logic [23:0]       RESULT,
    output logic              RESULT_VALID,
    output state_e            DBG_STATE
);

    localparam int                TW          = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TW-1:0]     TIMEOUT_VAL = TW'(ACK_TIMEOUT);
    localparam logic [15:0]       POLL_MAX    = 16'(POLL_LIMIT);
    localparam logic [ROM_AW-1:0] ROM_LAST    = {ROM_AW{1'b1}};

    state_e              r_state;
    state_e              w_next;
    cmd_e                r_cmd;
    cmd_e                w_rom_cmd;
    logic [ROM_AW-1:0]   r_rom_addr;
    logic [31:0]         r_addr;
    logic [7:0]          r_data;
    logic                r_we;
    logic [1:0]          r_slot;
    logic [23:0]         r_result;
    logic                r_result_valid;
    logic                r_fault;
    logic [1:0]          r_fault_code;
    logic                r_done;
    logic [TW-1:0]       r_timer;
    logic [15:0]         r_poll_cnt;
    logic                r_gap;
    logic                w_accept;
    logic                w_resp;
    logic                w_advance;
    logic                w_retry;
    logic                w_fault;
    logic [1:0]          w_fault_code;

    assign w_rom_cmd = cmd_e'(ROM_DATA[31:30]);

    always_ff @(posedge CLK) begin
        if (!rstn) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    // Handshake: a request is accepted on a cycle with CYC&STB&!STALL; ACK or ERR
    // may come in that same cycle or any later one, and only one request is in flight.
    always_comb begin
        w_next       = r_state;
        w_accept     = 1'b0;
        w_resp       = 1'b0;
        w_advance    = 1'b0;
        w_retry      = 1'b0;
        w_fault      = 1'b0;
        w_fault_code = FC_NONE;
        case (r_state)
            ST_IDLE:   if (START) w_next = ST_FETCH;
            ST_FETCH:  w_next = ST_DECODE;
            ST_DECODE: w_next = (w_rom_cmd == CMD_END) ? ST_IDLE : ST_REQ;
            ST_REQ: begin
                if (!r_gap && !STALL) begin
                    w_accept = 1'b1;
                    w_resp   = ACK | ERR;
                    if (!(ACK | ERR)) w_next = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                if (ACK | ERR) begin
                    w_resp = 1'b1;
                end else if (r_timer == TIMEOUT_VAL) begin
                    w_fault      = 1'b1;
                    w_fault_code = FC_ACK_TIMEOUT;
                end
            end
            ST_FAULT:  w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
        if (w_resp) begin
            if (ERR) begin
                w_fault      = 1'b1;
                w_fault_code = FC_WB_ERR;
            end else if (r_cmd == CMD_POLL) begin
                if (((RDATA & r_data) != 8'h00) || (r_data == 8'h00)) w_advance = 1'b1;
                else if (r_poll_cnt + 16'd1 == POLL_MAX) begin
                    w_fault      = 1'b1;
                    w_fault_code = FC_POLL_LIMIT;
                end else w_retry = 1'b1;
            end else begin
                w_advance = 1'b1;
            end
        end
        if (w_advance) begin
            if (r_rom_addr == ROM_LAST) begin
                w_fault      = 1'b1;
                w_fault_code = FC_POLL_LIMIT;
            end else w_next = ST_FETCH;
        end
        if (w_retry) w_next = ST_REQ;
        if (w_fault) w_next = ST_FAULT;
    end

    // A poll re-issue spends one REQ cycle with r_gap set so CYC drops between cycles.
    always_comb begin
        BUSY      = 1'b0;
        CYC       = 1'b0;
        STB       = 1'b0;
        DBG_STATE = r_state;
        case (r_state)
            ST_FETCH, ST_DECODE: BUSY = 1'b1;
            ST_REQ: begin
                BUSY = 1'b1;
                CYC  = !r_gap;
                STB  = !r_gap;
            end
            ST_WAIT_ACK: begin
                BUSY = 1'b1;
                CYC  = 1'b1;
            end
            default: ;
        endcase
        SEL = STB;
    end

    always_ff @(posedge CLK) begin
        if (!rstn) begin
            r_cmd          <= CMD_WRITE;
            r_rom_addr     <= '0;
            r_addr         <= '0;
            r_data         <= '0;
            r_we           <= 1'b0;
            r_slot         <= '0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_fault        <= 1'b0;
            r_fault_code   <= FC_NONE;
            r_done         <= 1'b0;
            r_timer        <= '0;
            r_poll_cnt     <= '0;
            r_gap          <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == ST_IDLE && START) begin
                r_rom_addr     <= '0;
                r_slot         <= '0;
                r_fault        <= 1'b0;
                r_fault_code   <= FC_NONE;
                r_result_valid <= 1'b0;
            end
            if (r_state == ST_DECODE) begin
                if (w_rom_cmd == CMD_END) begin
                    r_done         <= 1'b1;
                    r_result_valid <= 1'b1;
                end else begin
                    r_cmd      <= w_rom_cmd;
                    r_addr     <= BASE_ADDR + {10'b0, ROM_DATA[29:8]};
                    r_we       <= (w_rom_cmd == CMD_WRITE);
                    r_data     <= ROM_DATA[7:0];
                    r_poll_cnt <= '0;
                    r_gap      <= 1'b0;
                end
            end
            if (r_state == ST_REQ && r_gap) r_gap <= 1'b0;
            if (w_accept) r_timer <= TW'(1);
            if (r_state == ST_WAIT_ACK) r_timer <= r_timer + TW'(1);
            // Slot 2 is sticky: extra READs keep overwriting the last byte.
            if (w_resp && !ERR && r_cmd == CMD_READ) begin
                r_result[{r_slot, 3'b000} +: 8] <= RDATA;
                if (r_slot != 2'd2) r_slot <= r_slot + 2'd1;
            end
            if (w_retry) begin
                r_poll_cnt <= r_poll_cnt + 16'd1;
                r_gap      <= 1'b1;
            end
            if (w_advance && r_rom_addr != ROM_LAST) r_rom_addr <= r_rom_addr + 1'b1;
            if (w_fault) begin
                r_fault        <= 1'b1;
                r_fault_code   <= w_fault_code;
                r_result_valid <= 1'b0;
            end
        end
    end

    assign DONE         = r_done;
    assign FAULT        = r_fault;
    assign FAULT_CODE   = r_fault_code;
    assign ROM_ADDR     = r_rom_addr;
    assign WE           = r_we;
    assign ADDR         = r_addr;
    assign WDATA        = r_data;
    assign RESULT       = r_result;
    assign RESULT_VALID = r_result_valid;

endmodule

// File: tb/tb_wb_net_sequencer.sv
// Directed bench for wb_net_sequencer: command ROM beside the DUT, a reactive Wishbone
// slave, and a scoreboard of expected bus transactions.
module tb_wb_net_sequencer;
    import wb_net_sequencer_pkg::*;

    localparam int          AW   = 5;
    localparam logic [31:0] BASE = 32'h3000_0000;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start = 1'b0;
    logic          busy, done, fault, cyc, stb, we, sel, result_valid;
    logic [1:0]    fault_code;
    logic [AW-1:0] rom_addr;
    logic [31:0]   rom_data, addr;
    logic [7:0]    wdata;
    logic          stall = 1'b0, ack = 1'b0, err = 1'b0;
    logic [7:0]    rdata = 8'h00;
    logic [23:0]   result;
    state_e        dbg_state;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc_no = 0;

    // Scoreboard entry: {we, addr, wdata (0 for reads)}
    logic [40:0] exp_q[$];
    logic [7:0]  rd_q[$];

    int          stall_left = 0, cfg_stall = 0, strobe_run = 0;
    int          ack_lat = 1, wait_cnt = 0, resp_idx = 0, err_at = -1;
    int          accept_cyc = 0, end_cyc = 0;
    logic        no_ack = 1'b0, pending = 1'b0, pend_we = 1'b0, prev_cyc = 1'b0;
    logic        saw_done, saw_fault;
    logic [39:0] first_req;

    wb_net_sequencer #(.BASE_ADDR(BASE), .ROM_AW(AW), .ACK_TIMEOUT(8), .POLL_LIMIT(4)) u_dut (
        .CLK(clk), .rstn(rstn), .START(start), .BUSY(busy), .DONE(done), .FAULT(fault),
        .FAULT_CODE(fault_code), .ROM_ADDR(rom_addr), .ROM_DATA(rom_data), .CYC(cyc),
        .STB(stb), .WE(we), .ADDR(addr), .WDATA(wdata), .SEL(sel), .STALL(stall),
        .ACK(ack), .RDATA(rdata), .ERR(err), .RESULT(result), .RESULT_VALID(result_valid),
        .DBG_STATE(dbg_state)
    );

    wb_net_cmd_rom #(.AW(AW)) u_rom (.CLK(clk), .i_addr(rom_addr), .o_data(rom_data));

    always #5 clk = ~clk;
    always @(posedge clk) cyc_no++;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic respond();
        if (resp_idx == err_at) err = 1'b1;
        else                    ack = 1'b1;
        if (!pend_we) rdata = (rd_q.size() > 0) ? rd_q.pop_front() : 8'h00;
        resp_idx++;
    endtask

    // Slave model and bus monitor, sampled and driven on the falling edge.
    always @(negedge clk) begin
        logic [40:0] obs_t, exp_t;
        ack = 1'b0; err = 1'b0; rdata = 8'h00; stall = 1'b0;
        if (!rstn) begin
            pending = 1'b0;
        end else if (pending) begin
            if (wait_cnt == 0) begin
                respond();
                pending = 1'b0;
            end else wait_cnt--;
        end else if (cyc && stb) begin
            if (strobe_run == 0) begin
                check("cyc_gap", 64'(prev_cyc), 64'd0);
                cfg_stall = stall_left;
                first_req = {addr, wdata};
            end
            strobe_run++;
            if (stall_left > 0) begin
                stall = 1'b1;
                stall_left--;
            end else begin
                check("stb_hold", 64'(strobe_run), 64'(cfg_stall + 1));
                check("req_stable", 64'({addr, wdata}), 64'(first_req));
                check("sel", 64'(sel), 64'd1);
                obs_t = {we, addr, we ? wdata : 8'h00};
                exp_t = (exp_q.size() > 0) ? exp_q.pop_front() : 41'bx;
                check("txn", 64'(obs_t), 64'(exp_t));
                accept_cyc = cyc_no;
                pend_we    = we;
                strobe_run = 0;
                if (!no_ack) begin
                    if (ack_lat == 0) respond();
                    else begin
                        pending  = 1'b1;
                        wait_cnt = ack_lat - 1;
                    end
                end
            end
        end
        prev_cyc = cyc;
    end

    task automatic put(input logic [AW-1:0] idx, input cmd_e c, input logic [21:0] off,
                       input logic [7:0] d);
        u_rom.r_mem[idx] = mk_cmd(c, off, d);
    endtask

    task automatic exp_txn(input logic w, input logic [21:0] off, input logic [7:0] d);
        exp_q.push_back({w, BASE + {10'b0, off}, w ? d : 8'h00});
    endtask

    task automatic new_run();
        resp_idx = 0; err_at = -1; no_ack = 1'b0; ack_lat = 1; stall_left = 0;
        rd_q.delete();
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_end(input int max_cyc);
        saw_done = 1'b0; saw_fault = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (done)  begin saw_done = 1'b1;  end_cyc = cyc_no; break; end
            if (fault) begin saw_fault = 1'b1; end_cyc = cyc_no; break; end
        end
        check("run_ends", 64'(saw_done | saw_fault), 64'd1);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_ctrl"}, 64'({busy, done, fault, fault_code, rom_addr, cyc, stb, we, sel,
                                   result_valid}), 64'd0);
        check({tag, "_data"}, {addr, wdata, result}, 64'd0);
        check({tag, "_state"}, 64'(dbg_state), 64'(ST_IDLE));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset("reset");
        rstn = 1'b1;

        // Single write then END
        new_run();
        put(0, CMD_WRITE, 22'h40, 8'h12); put(1, CMD_END, 22'h0, 8'h00);
        exp_txn(1'b1, 22'h40, 8'h12);
        pulse_start(); wait_end(100);
        check("t1_done", 64'(saw_done), 64'd1);
        check("t1_fault", 64'(fault), 64'd0);
        check("t1_rv", 64'(result_valid), 64'd1);
        check("t1_rom_addr", 64'(rom_addr), 64'd1);
        check("t1_left", 64'(exp_q.size()), 64'd0);
        @(negedge clk);
        check("t1_done_pulse", 64'(done), 64'd0);

        // Stall 5 cycles on the first request; a START mid-run must be ignored
        new_run(); stall_left = 5;
        put(0, CMD_WRITE, 22'h44, 8'h34); put(1, CMD_WRITE, 22'h48, 8'h56);
        put(2, CMD_END, 22'h0, 8'h00);
        exp_txn(1'b1, 22'h44, 8'h34); exp_txn(1'b1, 22'h48, 8'h56);
        pulse_start();
        repeat (9) @(negedge clk);
        start = 1'b1; @(negedge clk); start = 1'b0;
        wait_end(100);
        check("t2_done", 64'(saw_done), 64'd1);
        check("t2_left", 64'(exp_q.size()), 64'd0);

        // Poll with three misses, then a mask-0 poll, then a write
        new_run();
        rd_q.push_back(8'h00); rd_q.push_back(8'h00); rd_q.push_back(8'h00);
        rd_q.push_back(8'h01); rd_q.push_back(8'h00);
        put(0, CMD_POLL, OFF_CORE_STATUS, 8'h01); put(1, CMD_POLL, OFF_CORE_STATUS, 8'h00);
        put(2, CMD_WRITE, OFF_CORE_CTRL, 8'h77); put(3, CMD_END, 22'h0, 8'h00);
        for (int i = 0; i < 5; i++) exp_txn(1'b0, OFF_CORE_STATUS, 8'h00);
        exp_txn(1'b1, OFF_CORE_CTRL, 8'h77);
        pulse_start(); wait_end(200);
        check("t3_done", 64'(saw_done), 64'd1);
        check("t3_left", 64'(exp_q.size()), 64'd0);

        // Three reads, ACK in the accept cycle
        new_run(); ack_lat = 0;
        rd_q.push_back(8'hA1); rd_q.push_back(8'hB2); rd_q.push_back(8'hC3);
        put(0, CMD_READ, OFF_OUTPUT_SOLUTION_0, 8'h00); put(1, CMD_READ, OFF_OUTPUT_SOLUTION_1, 8'h00);
        put(2, CMD_READ, OFF_OUTPUT_SOLUTION_2, 8'h00); put(3, CMD_END, 22'h0, 8'h00);
        exp_txn(1'b0, OFF_OUTPUT_SOLUTION_0, 8'h00); exp_txn(1'b0, OFF_OUTPUT_SOLUTION_1, 8'h00);
        exp_txn(1'b0, OFF_OUTPUT_SOLUTION_2, 8'h00);
        pulse_start(); wait_end(100);
        check("t4_done", 64'(saw_done), 64'd1);
        check("t4_result", 64'(result), 64'hC3B2A1);
        check("t4_rv", 64'(result_valid), 64'd1);

        // Four reads: slot saturates, the fourth overwrites slot 2
        new_run(); ack_lat = 2;
        rd_q.push_back(8'h11); rd_q.push_back(8'h22); rd_q.push_back(8'h33); rd_q.push_back(8'h44);
        for (int i = 0; i < 4; i++) begin
            put(AW'(i), CMD_READ, OFF_OUTPUT_SOLUTION_0, 8'h00);
            exp_txn(1'b0, OFF_OUTPUT_SOLUTION_0, 8'h00);
        end
        put(4, CMD_END, 22'h0, 8'h00);
        pulse_start();
        check("t4b_rv_cleared", 64'(result_valid), 64'd0);
        wait_end(100);
        check("t4b_result", 64'(result), 64'h442211);

        // ERR on the second write
        new_run(); err_at = 1;
        put(0, CMD_WRITE, 22'h50, 8'h01); put(1, CMD_WRITE, 22'h54, 8'h02);
        put(2, CMD_WRITE, 22'h58, 8'h03); put(3, CMD_END, 22'h0, 8'h00);
        exp_txn(1'b1, 22'h50, 8'h01); exp_txn(1'b1, 22'h54, 8'h02);
        pulse_start(); wait_end(100);
        check("t5_fault", 64'(saw_fault), 64'd1);
        check("t5_code", 64'(fault_code), 64'(FC_WB_ERR));
        check("t5_cyc", 64'({cyc, stb, busy, result_valid}), 64'd0);
        check("t5_left", 64'(exp_q.size()), 64'd0);
        repeat (3) @(negedge clk);
        check("t5_sticky", 64'({fault, done}), 64'b10);

        // ACK exactly ACK_TIMEOUT cycles after accept is still in time
        new_run(); ack_lat = 8;
        put(0, CMD_WRITE, 22'h60, 8'h0A); put(1, CMD_END, 22'h0, 8'h00);
        exp_txn(1'b1, 22'h60, 8'h0A);
        pulse_start(); wait_end(100);
        check("t6a_done", 64'(saw_done), 64'd1);

        // No ACK at all
        new_run(); no_ack = 1'b1;
        exp_txn(1'b1, 22'h60, 8'h0A);
        pulse_start(); wait_end(100);
        check("t6b_code", 64'(fault_code), 64'(FC_ACK_TIMEOUT));
        check("t6b_latency", 64'(end_cyc - accept_cyc), 64'd9);

        // Good script after a fault clears it
        new_run();
        exp_txn(1'b1, 22'h60, 8'h0A);
        pulse_start();
        check("t6c_fault_clear", 64'({fault, fault_code}), 64'd0);
        wait_end(100);
        check("t6c_done", 64'(saw_done), 64'd1);

        // Poll that never hits
        new_run();
        for (int i = 0; i < 4; i++) begin
            rd_q.push_back(8'hFE);
            exp_txn(1'b0, OFF_CORE_STATUS, 8'h00);
        end
        put(0, CMD_POLL, OFF_CORE_STATUS, 8'h01); put(1, CMD_END, 22'h0, 8'h00);
        pulse_start(); wait_end(200);
        check("t7_code", 64'({saw_fault, fault_code}), 64'({1'b1, FC_POLL_LIMIT}));
        check("t7_left", 64'(exp_q.size()), 64'd0);

        // ROM overrun: every entry is a write, no END
        new_run();
        for (int i = 0; i < 32; i++) begin
            put(AW'(i), CMD_WRITE, 22'(i), 8'(i + 3));
            exp_txn(1'b1, 22'(i), 8'(i + 3));
        end
        pulse_start(); wait_end(600);
        check("t8_code", 64'({saw_fault, fault_code}), 64'({1'b1, FC_POLL_LIMIT}));
        check("t8_left", 64'(exp_q.size()), 64'd0);

        // Reset while a request is stalled in REQ
        new_run(); stall_left = 20;
        put(0, CMD_WRITE, 22'h40, 8'h12); put(1, CMD_END, 22'h0, 8'h00);
        exp_txn(1'b1, 22'h40, 8'h12);
        pulse_start();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (stb) break;
        end
        check("t9_in_req", 64'(stb), 64'd1);
        rstn = 1'b0;
        @(negedge clk);
        check_reset("t9_reset");
        stall_left = 0; strobe_run = 0; exp_q.delete();
        @(negedge clk); rstn = 1'b1;

        new_run();
        exp_txn(1'b1, 22'h40, 8'h12);
        pulse_start(); wait_end(100);
        check("t9_recover", 64'({saw_done, fault}), 64'b10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
